// File: rtl/pkt_segmenter_pkg.sv
// Shared types and header-layout helpers for the DFX-word-to-Aurora-beat segmenter.
// The index width depends on the payload width, which in turn depends on the index width.
package pkt_segmenter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seg_state_e;

    localparam int ROUTER_ID_OFS = 0;

    function automatic int idx_ofs(input int rid_w);
        return rid_w;
    endfunction

    function automatic int ttl_ofs(input int rid_w, input int idx_w);
        return rid_w + idx_w;
    endfunction

    // Smallest index width that can still number every beat of its own payload split.
    function automatic int calc_idx_width(input int dw, input int aw, input int rw, input int tw);
        int res;
        int pw;
        int nb;
        res = 0;
        for (int iw = 1; iw < 32; iw++) begin
            pw = aw - rw - tw - iw;
            if (res == 0 && pw > 0) begin
                nb = (dw + pw - 1) / pw;
                if ($clog2(nb) <= iw) begin
                    res = iw;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pkt_segmenter_if.sv
// Source-side and Aurora-side handshake bundle of the segmenter.
// The master modport is the segmenter's own view; slave is the surrounding logic.
interface pkt_segmenter_if #(
    parameter int DATA_DFX_WIDTH    = 1034,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ROUTER_ID_WIDTH   = 2,
    parameter int TTL_WIDTH         = 2
);
    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_DFX_WIDTH-1:0]    s_data;
    logic [ROUTER_ID_WIDTH-1:0]   s_router_id;
    logic [TTL_WIDTH-1:0]         s_ttl;
    logic [AURORA_DATA_WIDTH-1:0] m_data;
    logic                         m_valid;
    logic                         m_ready;
    logic                         m_last;

    modport master (
        input  s_valid, s_data, s_router_id, s_ttl, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport slave (
        output s_valid, s_data, s_router_id, s_ttl, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/pkt_segmenter.sv
// Splits one wide DFX word into NUM_BEATS Aurora beats, each carrying router id, beat index and TTL.
// All beat outputs come straight from registers; the next beat is prepared one cycle ahead.
module pkt_segmenter
    import pkt_segmenter_pkg::*;
#(
    parameter int DATA_DFX_WIDTH    = 1034,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ROUTER_ID_WIDTH   = 2,
    parameter int TTL_WIDTH         = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pkt_segmenter_if.master bus,
    output logic            done,
    output logic            busy,
    output logic [15:0]     pkt_cnt
);

    localparam int IDX_WIDTH     = calc_idx_width(DATA_DFX_WIDTH, AURORA_DATA_WIDTH,
                                                  ROUTER_ID_WIDTH, TTL_WIDTH);
    localparam int HEADER_WIDTH  = ROUTER_ID_WIDTH + IDX_WIDTH + TTL_WIDTH;
    localparam int PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HEADER_WIDTH;
    localparam int NUM_BEATS     = (DATA_DFX_WIDTH + PAYLOAD_WIDTH - 1) / PAYLOAD_WIDTH;
    localparam int PAD_WIDTH     = NUM_BEATS * PAYLOAD_WIDTH;
    localparam int IDX_OFS       = idx_ofs(ROUTER_ID_WIDTH);
    localparam int TTL_OFS       = ttl_ofs(ROUTER_ID_WIDTH, IDX_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BEATS - 1);

    // Zero-extending the word to PAD_WIDTH makes the last beat's spare payload bits zero.
    function automatic logic [AURORA_DATA_WIDTH-1:0] build_beat(
        input logic [PAD_WIDTH-1:0]       word,
        input logic [IDX_WIDTH-1:0]       k,
        input logic [ROUTER_ID_WIDTH-1:0] rid,
        input logic [TTL_WIDTH-1:0]       ttl
    );
        logic [AURORA_DATA_WIDTH-1:0] beat;
        int unsigned                  shift;
        shift = 32'(k) * 32'(PAYLOAD_WIDTH);
        beat  = {AURORA_DATA_WIDTH{1'b0}};
        beat[ROUTER_ID_OFS +: ROUTER_ID_WIDTH] = rid;
        beat[IDX_OFS +: IDX_WIDTH]             = k;
        beat[TTL_OFS +: TTL_WIDTH]             = ttl;
        beat[HEADER_WIDTH +: PAYLOAD_WIDTH]    = PAYLOAD_WIDTH'(word >> shift);
        return beat;
    endfunction

    seg_state_e                   state_r, state_s;
    logic [IDX_WIDTH-1:0]         idx_r, idx_s, idx_nx_s;
    logic [DATA_DFX_WIDTH-1:0]    data_r, data_s;
    logic [ROUTER_ID_WIDTH-1:0]   rid_r, rid_s;
    logic [TTL_WIDTH-1:0]         ttl_r, ttl_s;
    logic [AURORA_DATA_WIDTH-1:0] m_data_r, m_data_s;
    logic                         m_valid_r, m_valid_s;
    logic                         m_last_r, m_last_s;
    logic                         done_r, done_s;
    logic [15:0]                  pkt_cnt_r, pkt_cnt_s;

    // Next-state and next-output decode; beat 0 is built from the inputs during the handshake.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        data_s    = data_r;
        rid_s     = rid_r;
        ttl_s     = ttl_r;
        m_data_s  = {AURORA_DATA_WIDTH{1'b0}};
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
        done_s    = 1'b0;
        pkt_cnt_s = pkt_cnt_r;
        idx_nx_s  = idx_r + IDX_WIDTH'(1'b1);
        case (state_r)
            IDLE: begin
                if (bus.s_valid) begin
                    state_s   = SEND;
                    idx_s     = {IDX_WIDTH{1'b0}};
                    data_s    = bus.s_data;
                    rid_s     = bus.s_router_id;
                    ttl_s     = bus.s_ttl;
                    m_valid_s = 1'b1;
                    m_data_s  = build_beat(PAD_WIDTH'(bus.s_data), {IDX_WIDTH{1'b0}},
                                           bus.s_router_id, bus.s_ttl);
                    m_last_s  = (NUM_BEATS == 1);
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_s   = DONE;
                        done_s    = 1'b1;
                        pkt_cnt_s = pkt_cnt_r + 16'd1;
                    end else begin
                        idx_s     = idx_nx_s;
                        m_valid_s = 1'b1;
                        m_data_s  = build_beat(PAD_WIDTH'(data_r), idx_nx_s, rid_r, ttl_r);
                        m_last_s  = (idx_nx_s == LAST_IDX);
                    end
                end else begin
                    m_valid_s = 1'b1;
                    m_data_s  = m_data_r;
                    m_last_s  = m_last_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_WIDTH{1'b0}};
            data_r    <= {DATA_DFX_WIDTH{1'b0}};
            rid_r     <= {ROUTER_ID_WIDTH{1'b0}};
            ttl_r     <= {TTL_WIDTH{1'b0}};
            m_data_r  <= {AURORA_DATA_WIDTH{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            done_r    <= 1'b0;
            pkt_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            data_r    <= data_s;
            rid_r     <= rid_s;
            ttl_r     <= ttl_s;
            m_data_r  <= m_data_s;
            m_valid_r <= m_valid_s;
            m_last_r  <= m_last_s;
            done_r    <= done_s;
            pkt_cnt_r <= pkt_cnt_s;
        end
    end

    assign bus.s_ready = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_last  = m_last_r;
    assign done        = done_r;
    assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_pkt_segmenter.sv
// Randomized self-checking bench for pkt_segmenter with a bit-level reference model of the beat layout.
module tb_pkt_segmenter;

    localparam int D  = 1034;
    localparam int AW = 64;
    localparam int RW = 2;
    localparam int TW = 2;
    localparam int PW = 55;
    localparam int NB = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done;
    logic        busy;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    pkt_segmenter_if #(.DATA_DFX_WIDTH(D), .AURORA_DATA_WIDTH(AW),
                       .ROUTER_ID_WIDTH(RW), .TTL_WIDTH(TW)) bus ();

    pkt_segmenter #(.DATA_DFX_WIDTH(D), .AURORA_DATA_WIDTH(AW),
                    .ROUTER_ID_WIDTH(RW), .TTL_WIDTH(TW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .done    (done),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] obs_data[$];
    bit          obs_last[$];
    int          obs_cyc[$];
    logic [63:0] exp_data[$];
    bit          exp_last[$];
    int          hs_cyc[$];
    int          hs_sready[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_acc_cyc = 0;
    int          sready_run = 0;
    int          stall_left = 0;
    int          ready_mode = 0;
    bit          prev_stall = 1'b0;
    bit          prev_last = 1'b0;
    bit          prev_done = 1'b0;
    logic [63:0] prev_data = 64'd0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat k: router id at bits 1:0, index at 6:2, TTL at 8:7, payload bits from 9 upward.
    function automatic logic [63:0] ref_beat(input logic [D-1:0] w, input int k,
                                             input logic [RW-1:0] rid, input logic [TW-1:0] ttl);
        logic [63:0] b;
        b = 64'(rid) | (64'(k) << 2) | (64'(ttl) << 7);
        for (int j = 0; j < PW; j++) begin
            if (k * PW + j < D) b[9 + j] = w[k * PW + j];
        end
        return b;
    endfunction

    function automatic logic [D-1:0] rand_word();
        logic [1055:0] t;
        for (int i = 0; i < 33; i++) t[i * 32 +: 32] = $urandom;
        return t[D-1:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Aurora-side ready pattern generator.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    if (obs_data.size() == 7 && stall_left > 0) begin
                        bus.m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.m_ready = ~bus.m_ready;
                    end
                end
                2: bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: collects accepted beats and checks per-cycle protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.m_valid && bus.m_ready) begin
                    obs_data.push_back(bus.m_data);
                    obs_last.push_back(bus.m_last);
                    obs_cyc.push_back(cyc);
                    last_acc_cyc = cyc;
                end
                if (!bus.m_valid) check_val("idle_outputs_zero", bus.m_data | 64'(bus.m_last), 64'd0);
                if (prev_stall) begin
                    check_val("stall_valid", 64'(bus.m_valid), 64'd1);
                    check_val("stall_data", bus.m_data, prev_data);
                    check_val("stall_last", 64'(bus.m_last), 64'(prev_last));
                end
                if (bus.s_ready) begin
                    if (bus.s_valid) begin
                        hs_cyc.push_back(cyc);
                        hs_sready.push_back(sready_run);
                        sready_run = 0;
                    end else begin
                        sready_run++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    check_val("done_after_last", 64'(cyc - last_acc_cyc), 64'd1);
                    check_val("done_single", 64'(prev_done), 64'd0);
                    check_val("done_mvalid_low", 64'(bus.m_valid), 64'd0);
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
                prev_done  = done;
            end else begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                sready_run = 0;
            end
        end
    end

    task automatic push_expected(input logic [D-1:0] w, input logic [RW-1:0] r, input logic [TW-1:0] t);
        for (int k = 0; k < NB; k++) begin
            exp_data.push_back(ref_beat(w, k, r, t));
            exp_last.push_back(k == NB - 1);
        end
    endtask

    task automatic wait_handshake(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (bus.s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check_val("input_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_word(input logic [D-1:0] w, input logic [RW-1:0] r, input logic [TW-1:0] t);
        bit ok;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data = w;
        bus.s_router_id = r;
        bus.s_ttl = t;
        wait_handshake(ok);
        bus.s_valid = 1'b0;
        bus.s_data = rand_word();
        bus.s_router_id = 2'($urandom);
        bus.s_ttl = 2'($urandom);
        push_expected(w, r, t);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", 64'(done_cnt >= target), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_packets(input bit contiguous);
        int n;
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        check_val("beat_count", 64'(obs_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("p%0d_beat%0d_data", i / NB, i % NB), obs_data[i], exp_data[i]);
            check_val($sformatf("p%0d_beat%0d_last", i / NB, i % NB), 64'(obs_last[i]), 64'(exp_last[i]));
            if (contiguous && (i / NB) < hs_cyc.size())
                check_val($sformatf("p%0d_beat%0d_timing", i / NB, i % NB),
                          64'(obs_cyc[i] - hs_cyc[i / NB]), 64'(i % NB + 1));
        end
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        exp_data.delete();
        exp_last.delete();
        hs_cyc.delete();
        hs_sready.delete();
    endtask

    task automatic run_packet(input logic [D-1:0] w, input logic [RW-1:0] r,
                              input logic [TW-1:0] t, input bit contiguous);
        int tgt;
        tgt = done_cnt + 1;
        send_word(w, r, t);
        wait_done(tgt);
        exp_cnt = exp_cnt + 16'd1;
        compare_packets(contiguous);
        check_val("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] w;
        logic [D-1:0] w2;
        logic [RW-1:0] r;
        logic [TW-1:0] t;
        bit ok;
        int tgt;
        int done_before;

        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_router_id = 2'd0;
        bus.s_ttl = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check_val("rst_m_data", bus.m_data, 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Alternating-bit word, continuous ready.
        for (int i = 0; i < D; i++) w[i] = i[0];
        ready_mode = 0;
        run_packet(w, 2'd2, 2'd3, 1'b1);

        // All-ones word exposes last-beat padding.
        w = '1;
        run_packet(w, 2'($urandom), 2'($urandom), 1'b1);

        // Toggling ready with a 5-cycle stall on beat 7.
        ready_mode = 1;
        stall_left = 5;
        run_packet(rand_word(), 2'($urandom), 2'($urandom), 1'b0);
        check_val("stall_used", 64'(stall_left), 64'd0);
        ready_mode = 0;

        // Back-to-back words with s_valid held high.
        w  = rand_word();
        w2 = rand_word();
        r  = 2'($urandom);
        t  = 2'($urandom);
        tgt = done_cnt + 2;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data = w;
        bus.s_router_id = r;
        bus.s_ttl = t;
        wait_handshake(ok);
        push_expected(w, r, t);
        r = ~r;
        t = t + 2'd1;
        bus.s_data = w2;
        bus.s_router_id = r;
        bus.s_ttl = t;
        wait_handshake(ok);
        push_expected(w2, r, t);
        bus.s_valid = 1'b0;
        wait_done(tgt);
        exp_cnt = exp_cnt + 16'd2;
        check_val("b2b_hs_count", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() >= 2) begin
            check_val("b2b_period", 64'(hs_cyc[1] - hs_cyc[0]), 64'd21);
            check_val("b2b_sready_gap", 64'(hs_sready[1]), 64'd0);
        end
        compare_packets(1'b1);
        check_val("b2b_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));

        // Random data under random backpressure.
        ready_mode = 2;
        for (int p = 0; p < 6; p++) run_packet(rand_word(), 2'($urandom), 2'($urandom), 1'b0);
        ready_mode = 0;

        // Reset while beat 10 is on the bus.
        send_word(rand_word(), 2'($urandom), 2'($urandom));
        for (int n = 0; n < 200 && obs_data.size() < 10; n++) @(negedge clk);
        @(posedge clk);
        #1;
        check_val("rst_mid_beat_idx", 64'(bus.m_data[6:2]), 64'd10);
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_m_valid", 64'(bus.m_valid), 64'd0);
        check_val("rst_mid_m_data", bus.m_data, 64'd0);
        check_val("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        exp_data.delete();
        exp_last.delete();
        hs_cyc.delete();
        hs_sready.delete();
        exp_cnt = 16'd0;
        repeat (30) @(negedge clk);
        check_val("rst_mid_no_done", 64'(done_cnt), 64'(done_before));
        check_val("rst_mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check_val("rst_mid_s_ready", 64'(bus.s_ready), 64'd1);
        run_packet(rand_word(), 2'($urandom), 2'($urandom), 1'b1);

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.pkt_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_cnt_r;
        @(negedge clk);
        check_val("wrap_preload", 64'(pkt_cnt), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        run_packet(rand_word(), 2'($urandom), 2'($urandom), 1'b1);
        check_val("wrap_zero", 64'(pkt_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_segmenter.md
PKT_SEGMENTER -- requirements
Module: pkt_segmenter

Interface
REQ-001 Parameter DATA_DFX_WIDTH, default 1034, width of the DFX word (data plus address) to segment.
REQ-002 Parameter AURORA_DATA_WIDTH, default 64, width of one output beat.
REQ-003 Parameter ROUTER_ID_WIDTH, default 2, router-recognition field width.
REQ-004 Parameter TTL_WIDTH, default 2, TTL field width.
REQ-005 The following SHALL be derived localparams:
- NUM_BEATS = ceil(DATA_DFX_WIDTH/PAYLOAD_WIDTH)
- IDX_WIDTH = clog2(NUM_BEATS)
- HEADER_WIDTH = ROUTER_ID_WIDTH+IDX_WIDTH+TTL_WIDTH
- PAYLOAD_WIDTH = AURORA_DATA_WIDTH-HEADER_WIDTH
- With defaults: 19, 5, 9, 55.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 s_valid  input  1  source offers a DFX word.
REQ-009 s_ready  output  1  block can accept a DFX word.
REQ-010 s_data  input  DATA_DFX_WIDTH  DFX word.
REQ-011 s_router_id  input  ROUTER_ID_WIDTH  destination router id.
REQ-012 s_ttl  input  TTL_WIDTH  TTL value.
REQ-013 m_data  output  AURORA_DATA_WIDTH  beat to the Aurora TX.
REQ-014 m_valid  output  1  m_data is valid.
REQ-015 m_ready  input  1  Aurora TX accepts a beat.
REQ-016 m_last  output  1  marks beat NUM_BEATS-1.
REQ-017 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 pkt_cnt  output  16  count of completed packets, wrapping.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-021 s_ready SHALL be 1 only in IDLE.
REQ-022 An input handshake (s_valid && s_ready) SHALL capture s_data, s_router_id and s_ttl into registers and move to SEND.
REQ-023 Inputs SHALL be ignored outside an input handshake.
REQ-024 m_valid SHALL assert the cycle after the input handshake, carrying beat 0.
REQ-025 Beat k layout SHALL be:
- m_data[ROUTER_ID_WIDTH-1:0] = router id
- next IDX_WIDTH bits = k
- next TTL_WIDTH bits = TTL
- upper PAYLOAD_WIDTH bits = captured word bits [k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
REQ-026 Payload bits beyond DATA_DFX_WIDTH in the last beat SHALL be zero.
REQ-027 While m_valid && !m_ready, m_data, m_last and the beat index SHALL hold stable.
REQ-028 m_valid SHALL NOT deassert before the beat handshake completes.
REQ-029 On handshake (m_valid && m_ready) of beat k < NUM_BEATS-1, beat k+1 SHALL present the next cycle, giving zero bubbles under continuous m_ready.
REQ-030 m_last SHALL equal (k == NUM_BEATS-1) while m_valid is high, and 0 otherwise.
REQ-031 The handshake of the last beat SHALL go to DONE, with m_valid=0 the next cycle.
REQ-032 In DONE, done SHALL be 1 for exactly one cycle, pkt_cnt SHALL increment by 1 (0xFFFF wraps to 0), and the next state SHALL be IDLE.
REQ-033 Minimum packet period SHALL be NUM_BEATS+2 cycles (handshake, NUM_BEATS beats, DONE); s_ready re-asserts the cycle after DONE.
REQ-034 m_data, m_valid, m_last, done SHALL all be registered outputs with no combinational input-to-output path; s_ready and busy decode the state register.
REQ-035 m_data SHALL be zero whenever m_valid is 0.
REQ-036 The beat index SHALL reset to 0 on entry to SEND and never exceed NUM_BEATS-1.

Reset
REQ-037 On rst_n low, asynchronously:
- state=IDLE, beat index=0, captured registers=0
- m_data=0, m_valid=0, m_last=0, done=0, pkt_cnt=0
- so s_ready=1, busy=0 after release.
REQ-038 Reset mid-packet SHALL abandon the packet without a done pulse or pkt_cnt increment; the first post-reset beat SHALL be beat 0 of a new packet.

Structure
REQ-039 Package pkt_segmenter_pkg SHALL hold the state enum (IDLE, SEND, DONE) and the header-field offset constants (router id at 0, index at ROUTER_ID_WIDTH, TTL at ROUTER_ID_WIDTH+IDX_WIDTH).
REQ-040 The block SHALL be one flat module; no sub-module is required.

Verification
REQ-041 Default parameters, s_data=1034'h…(bit i = i[0]), router_id=2, ttl=3, m_ready=1 -> 19 consecutive beats; beat k header = {2'd3, k[4:0], 2'd2}; m_last only on beat 18; done pulses 1 cycle after; pkt_cnt=1.
REQ-042 Last-beat padding: s_data all ones -> beat 18 payload = 11'b0 followed by 44 ones (bits 1033:990); beats 0-17 payload all ones.
REQ-043 Backpressure: m_ready toggles every cycle, plus a 5-cycle low stall on beat 7 -> m_data stable throughout each stall; still 19 beats in order; no beat duplicated or lost.
REQ-044 Back-to-back: s_valid held high with two words -> second input handshake exactly 21 cycles after the first; s_ready=0 throughout; pkt_cnt=2.
REQ-045 Reset mid-packet: rst_n pulsed low during beat 10 -> m_valid=0 immediately; done never pulses; pkt_cnt=0; next packet starts at index 0.
REQ-046 Wrap: force pkt_cnt=0xFFFF, send one packet -> pkt_cnt=0x0000.
